// File: rtl/fifo_rr_arbiter_if.sv
// Bus bundle between the round-robin FIFO sequencer and its environment:
// producer requests/grants, consumer pop handshake, flush control and the
// pins that drive the shared FIFO.
interface fifo_rr_arbiter_if #(
  parameter int N = 4,
  parameter int M = 2,
  parameter int K = 4
);
  localparam int OCC_W = $clog2(N) + 1;

  logic [K-1:0]     req;
  logic [K*M-1:0]   req_data;
  logic [K-1:0]     gnt;
  logic             pop_req;
  logic             pop_ack;
  logic             flush;
  logic             flush_busy;
  logic             fifo_push;
  logic             fifo_pop;
  logic [M-1:0]     fifo_in;
  logic             fifo_full;
  logic [OCC_W-1:0] occ;
  logic             empty;

  // The sequencer side.
  modport master (
    input  req, req_data, pop_req, flush, fifo_full,
    output gnt, pop_ack, flush_busy, fifo_push, fifo_pop, fifo_in, occ, empty
  );

  // The requesters, consumer and FIFO side.
  modport slave (
    output req, req_data, pop_req, flush, fifo_full,
    input  gnt, pop_ack, flush_busy, fifo_push, fifo_pop, fifo_in, occ, empty
  );
endinterface

// File: rtl/fifo_rr_arbiter.sv
// Round-robin push arbiter and pop sequencer in front of a single N x M FIFO.
// Keeps a local occupancy count (the FIFO only exposes full), never issues a
// push the FIFO would drop, and can drain the FIFO on a flush pulse.
module fifo_rr_arbiter #(
  parameter int N = 4,
  parameter int M = 2,
  parameter int K = 4
) (
  input  logic              clk,
  input  logic              reset,
  fifo_rr_arbiter_if.master bus
);

  localparam int OCC_W = $clog2(N) + 1;
  localparam int IDX_W = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q;
  logic [OCC_W-1:0] occ_q, occ_d;

  logic [K-1:0]     gnt_q;
  logic             fifo_push_q;
  logic             fifo_pop_q;
  logic [M-1:0]     fifo_in_q;
  logic             pop_ack_q;
  logic             flush_busy_q;

  logic             any_req;
  logic             pop_ok;
  logic             push_ok;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] winner;
  logic [K-1:0]     win_onehot;
  logic [M-1:0]     win_data;
  logic             do_push;
  logic             do_pop;
  logic             do_ack;

  assign any_req = |bus.req;
  assign pop_ok  = bus.pop_req && (occ_q != '0);
  // A push is safe when there is room, or when a pop frees a slot on the same edge.
  assign push_ok = any_req && ((occ_q < OCC_W'(N)) || pop_ok);

  // Round-robin scan: first asserted request after the last winner, wrapping at K.
  // NOTE: every variable written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    winner     = rr_ptr_q;
    win_onehot = '0;
    win_data   = '0;
    cand       = '0;
    for (int off = 1; off <= K; off++) begin
      cand = IDX_W'((int'(rr_ptr_q) + off) % K);
      if ((win_onehot == '0) && bus.req[cand]) begin
        winner           = cand;
        win_onehot[cand] = 1'b1;
      end
    end
    for (int i = 0; i < K; i++) begin
      if (win_onehot[i]) win_data = bus.req_data[i*M +: M];
    end
  end

  // Next-state and push/pop decisions; flush wins over any other request.
  always_comb begin
    state_d = state_q;
    do_push = 1'b0;
    do_pop  = 1'b0;
    do_ack  = 1'b0;
    unique case (state_q)
      IDLE, ARB: begin
        if (bus.flush) begin
          state_d = FLUSH;
        end else begin
          do_pop  = pop_ok;
          do_ack  = pop_ok;
          do_push = push_ok;
          state_d = (any_req || bus.pop_req) ? ARB : IDLE;
        end
      end
      FLUSH: begin
        // Drained words are discarded, so the consumer sees no pop_ack.
        if (occ_q != '0) begin
          do_pop = 1'b1;
          if (occ_q == OCC_W'(1)) state_d = IDLE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Occupancy follows the issued commands; push and pop together cancel out.
  always_comb begin
    occ_d = occ_q;
    if (do_push && !do_pop)      occ_d = occ_q + OCC_W'(1);
    else if (do_pop && !do_push) occ_d = occ_q - OCC_W'(1);
  end

  // State, pointer, occupancy and all registered pins.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= IDX_W'(K - 1);
      occ_q        <= '0;
      gnt_q        <= '0;
      fifo_push_q  <= 1'b0;
      fifo_pop_q   <= 1'b0;
      fifo_in_q    <= '0;
      pop_ack_q    <= 1'b0;
      flush_busy_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      occ_q        <= occ_d;
      gnt_q        <= do_push ? win_onehot : '0;
      fifo_push_q  <= do_push;
      fifo_in_q    <= do_push ? win_data : '0;
      fifo_pop_q   <= do_pop;
      pop_ack_q    <= do_ack;
      flush_busy_q <= (state_d == FLUSH);
      if (do_push) rr_ptr_q <= winner;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.fifo_push  = fifo_push_q;
  assign bus.fifo_pop   = fifo_pop_q;
  assign bus.fifo_in    = fifo_in_q;
  assign bus.pop_ack    = pop_ack_q;
  assign bus.flush_busy = flush_busy_q;
  assign bus.occ        = occ_q;
  assign bus.empty      = (occ_q == '0);

  // The FIFO acts on the pins one edge after occ moves, so its full flag must
  // match the occupancy held during the previous cycle.
  full_tracks_occ: assert property (
    @(posedge clk) disable iff (!reset)
    bus.fifo_full == ($past(occ_q) == OCC_W'(N))
  );

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench for fifo_rr_arbiter: expected FIFO-side events are queued as
// stimulus is issued and a negedge monitor pops and compares each one.
module tb_fifo_rr_arbiter;

  localparam int N     = 4;
  localparam int M     = 2;
  localparam int K     = 4;
  localparam int OCC_W = $clog2(N) + 1;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fifo_rr_arbiter_if #(.N(N), .M(M), .K(K)) bus ();

  fifo_rr_arbiter #(.N(N), .M(M), .K(K)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural FIFO occupancy, driving the full flag from the pins.
  int fifo_cnt;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_cnt <= 0;
    end else if (bus.fifo_push && !bus.fifo_pop && fifo_cnt < N) begin
      fifo_cnt <= fifo_cnt + 1;
    end else if (bus.fifo_pop && !bus.fifo_push && fifo_cnt > 0) begin
      fifo_cnt <= fifo_cnt - 1;
    end
  end
  assign bus.fifo_full = (fifo_cnt == N);

  typedef struct packed {
    logic [K-1:0]     gnt;
    logic             push;
    logic [M-1:0]     din;
    logic             pop;
    logic             ack;
    logic [OCC_W-1:0] occ;
  } ev_t;

  ev_t sb[$];
  ev_t mon_exp;
  ev_t mon_act;
  int  ev_idx   = 0;
  int  checks   = 0;
  int  failures = 0;

  logic [M-1:0] dval [K] = '{2'b01, 2'b10, 2'b11, 2'b00};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic ev_t mk_ev(input logic [K-1:0] g, input logic p, input logic [M-1:0] d,
                                input logic pp, input logic a, input logic [OCC_W-1:0] o);
    ev_t e;
    e.gnt  = g;
    e.push = p;
    e.din  = d;
    e.pop  = pp;
    e.ack  = a;
    e.occ  = o;
    return e;
  endfunction

  task automatic expect_push(input int who, input int occ_after);
    logic [K-1:0] oh;
    oh      = '0;
    oh[who] = 1'b1;
    sb.push_back(mk_ev(oh, 1'b1, dval[who], 1'b0, 1'b0, OCC_W'(occ_after)));
  endtask

  task automatic expect_pop(input logic ack, input int occ_after);
    sb.push_back(mk_ev('0, 1'b0, '0, 1'b1, ack, OCC_W'(occ_after)));
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_idle_pins(input string name);
    check(name, 32'({bus.gnt, bus.fifo_push, bus.fifo_pop, bus.fifo_in, bus.pop_ack,
                     bus.flush_busy, bus.occ, bus.empty}), 32'(1));
  endtask

  // Monitor: every cycle with FIFO-side activity must match the next queued event.
  always @(negedge clk) begin
    if (reset && (bus.gnt != '0 || bus.fifo_push || bus.fifo_pop || bus.pop_ack)) begin
      check($sformatf("event%0d_expected", ev_idx), 32'(sb.size() != 0), 32'(1));
      if (sb.size() != 0) begin
        mon_exp = sb.pop_front();
        mon_act = mk_ev(bus.gnt, bus.fifo_push, bus.fifo_in, bus.fifo_pop, bus.pop_ack, bus.occ);
        check($sformatf("event%0d", ev_idx), 32'(mon_act), 32'(mon_exp));
      end
      ev_idx++;
    end
  end

  initial begin
    reset       = 1'b1;
    bus.req     = '0;
    bus.pop_req = 1'b0;
    bus.flush   = 1'b0;
    for (int i = 0; i < K; i++) bus.req_data[i*M +: M] = dval[i];
    #2 reset = 1'b0;
    tick(2);
    check_idle_pins("reset_outputs");
    reset = 1'b1;

    // All four requesters: rotating grants until full, then nothing.
    expect_push(0, 1);
    expect_push(1, 2);
    expect_push(2, 3);
    expect_push(3, 4);
    bus.req = 4'b1111;
    tick(6);
    check("fill_occ", 32'(bus.occ), 32'(4));
    check("fill_no_gnt_when_full", 32'(bus.gnt), 32'(0));
    check("fill_drained", 32'(sb.size()), 32'(0));
    bus.req = '0;
    tick(1);

    // Push and pop together at full: both issued, occupancy holds.
    sb.push_back(mk_ev(4'b0100, 1'b1, dval[2], 1'b1, 1'b1, OCC_W'(4)));
    bus.req     = 4'b0100;
    bus.pop_req = 1'b1;
    tick(1);
    bus.req     = '0;
    bus.pop_req = 1'b0;
    tick(1);
    check("pushpop_occ", 32'(bus.occ), 32'(4));
    check("pushpop_drained", 32'(sb.size()), 32'(0));

    // Consumer drains to empty, then further pop requests are refused.
    expect_pop(1'b1, 3);
    expect_pop(1'b1, 2);
    expect_pop(1'b1, 1);
    expect_pop(1'b1, 0);
    bus.pop_req = 1'b1;
    tick(6);
    check("underflow_occ", 32'(bus.occ), 32'(0));
    check("underflow_empty", 32'(bus.empty), 32'(1));
    check("underflow_no_pop", 32'({bus.fifo_pop, bus.pop_ack}), 32'(0));
    check("underflow_drained", 32'(sb.size()), 32'(0));
    bus.pop_req = 1'b0;
    tick(1);

    // Fill to 3 from requester 0, then flush while it keeps requesting.
    expect_push(0, 1);
    expect_push(0, 2);
    expect_push(0, 3);
    bus.req = 4'b0001;
    tick(3);
    check("preflush_occ", 32'(bus.occ), 32'(3));
    expect_pop(1'b0, 2);
    expect_pop(1'b0, 1);
    expect_pop(1'b0, 0);
    bus.flush = 1'b1;
    tick(1);
    bus.flush = 1'b0;
    check("flush_busy_c1", 32'(bus.flush_busy), 32'(1));
    tick(1);
    check("flush_busy_c2", 32'(bus.flush_busy), 32'(1));
    tick(1);
    check("flush_busy_c3", 32'(bus.flush_busy), 32'(1));
    expect_push(0, 1);
    tick(1);
    check("flush_done_busy", 32'(bus.flush_busy), 32'(0));
    check("flush_done_occ", 32'(bus.occ), 32'(0));
    tick(1);
    bus.req = '0;
    check("postflush_occ", 32'(bus.occ), 32'(1));
    tick(2);
    check("flush_drained", 32'(sb.size()), 32'(0));

    // Wrap-around fairness after a grant to requester 1.
    expect_push(1, 2);
    bus.req = 4'b0010;
    tick(1);
    expect_push(3, 3);
    expect_push(1, 4);
    bus.req = 4'b1010;
    tick(2);
    bus.req = '0;
    tick(2);
    check("rr_occ", 32'(bus.occ), 32'(4));
    check("rr_drained", 32'(sb.size()), 32'(0));

    // Drain to 2, start a flush, then reset asynchronously mid-flush.
    expect_pop(1'b1, 3);
    expect_pop(1'b1, 2);
    bus.pop_req = 1'b1;
    tick(2);
    bus.pop_req = 1'b0;
    tick(1);
    check("midflush_pre_occ", 32'(bus.occ), 32'(2));
    bus.flush = 1'b1;
    tick(1);
    bus.flush = 1'b0;
    check("midflush_busy", 32'({bus.flush_busy, bus.occ}), 32'({1'b1, 3'd2}));
    #2 reset = 1'b0;
    #1;
    check_idle_pins("async_reset_outputs");
    check("async_reset_drained", 32'(sb.size()), 32'(0));
    tick(2);
    reset = 1'b1;
    expect_push(0, 1);
    bus.req = 4'b1111;
    tick(1);
    bus.req = '0;
    tick(3);
    check("post_reset_occ", 32'(bus.occ), 32'(1));
    check("post_reset_drained", 32'(sb.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
